// File: rtl/sgd_mem_rd_scheduler.sv
// Shares one memory read-command channel between requesters A and B: splits requests into
// bounded bursts, arbitrates round-robin per request, and steers read data by an in-order owner FIFO.
module sgd_mem_rd_scheduler #(
    parameter int         DATA_WIDTH      = 512,
    parameter int         MAX_BURST_BYTES = 4096,
    parameter int         MAX_OUTSTANDING = 16,
    parameter logic [7:0] TAG_A           = 8'h0a,
    parameter logic [7:0] TAG_B           = 8'h0b
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_cmd_valid,
    output logic                    a_cmd_ready,
    input  logic [63:0]             a_cmd_address,
    input  logic [31:0]             a_cmd_length,
    input  logic                    b_cmd_valid,
    output logic                    b_cmd_ready,
    input  logic [63:0]             b_cmd_address,
    input  logic [31:0]             b_cmd_length,
    output logic                    m_cmd_valid,
    input  logic                    m_cmd_ready,
    output logic [63:0]             m_cmd_address,
    output logic [31:0]             m_cmd_length,
    output logic [7:0]              m_cmd_tag,
    input  logic                    s_rd_valid,
    output logic                    s_rd_ready,
    input  logic [DATA_WIDTH-1:0]   s_rd_data,
    input  logic [DATA_WIDTH/8-1:0] s_rd_keep,
    input  logic                    s_rd_last,
    output logic                    a_rd_valid,
    input  logic                    a_rd_ready,
    output logic [DATA_WIDTH-1:0]   a_rd_data,
    output logic [DATA_WIDTH/8-1:0] a_rd_keep,
    output logic                    a_rd_last,
    output logic                    b_rd_valid,
    input  logic                    b_rd_ready,
    output logic [DATA_WIDTH-1:0]   b_rd_data,
    output logic [DATA_WIDTH/8-1:0] b_rd_keep,
    output logic                    b_rd_last,
    output logic                    busy
);
    localparam int              PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int              CW        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0]     BURST_MAX = 32'(MAX_BURST_BYTES);
    localparam logic [CW-1:0]   OUT_MAX   = CW'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] remaining;
        logic        owner;      // 0 = A, 1 = B
    } req_t;

    state_t                     state, state_nxt;
    req_t                       req;
    logic                       pri;
    logic [CW-1:0]              outstanding;
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [MAX_OUTSTANDING-1:0] owner_fifo;

    logic        grant_a, grant_b, granted;
    logic [31:0] gnt_len, burst_len;
    logic        m_hs, last_burst, push, pop, fifo_empty, head;

    // pri = 0 favours A, pri = 1 favours B
    assign grant_a    = a_cmd_valid && (!pri || !b_cmd_valid);
    assign grant_b    = b_cmd_valid && (pri || !a_cmd_valid);
    assign granted    = a_cmd_ready || b_cmd_ready;
    assign gnt_len    = b_cmd_ready ? b_cmd_length : a_cmd_length;
    assign burst_len  = (req.remaining > BURST_MAX) ? BURST_MAX : req.remaining;
    assign last_burst = (req.remaining == burst_len);
    assign m_hs       = m_cmd_valid && m_cmd_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (granted) state_nxt = (gnt_len != 32'd0) ? ISSUE : IDLE;
            ISSUE:   if (m_hs && last_burst) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cmd_ready is gated by rst so nothing can be accepted while reset is held
    always_comb begin
        a_cmd_ready = 1'b0;
        b_cmd_ready = 1'b0;
        m_cmd_valid = 1'b0;
        m_cmd_tag   = 8'h00;
        case (state)
            IDLE: begin
                a_cmd_ready = !rst && grant_a;
                b_cmd_ready = !rst && grant_b;
            end
            ISSUE: begin
                m_cmd_valid = (outstanding < OUT_MAX);
                m_cmd_tag   = req.owner ? TAG_B : TAG_A;
            end
            default: ;
        endcase
    end

    assign m_cmd_address = req.addr;
    assign m_cmd_length  = burst_len;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            req <= '0;
            pri <= 1'b0;
        end else if (granted) begin
            req.addr      <= b_cmd_ready ? b_cmd_address : a_cmd_address;
            req.remaining <= gnt_len;
            req.owner     <= b_cmd_ready;
            pri           <= !b_cmd_ready;
        end else if (m_hs) begin
            req.addr      <= req.addr + 64'(burst_len);
            req.remaining <= req.remaining - burst_len;
        end

    assign push       = m_hs;
    assign pop        = s_rd_valid && s_rd_ready && s_rd_last;
    assign fifo_empty = (outstanding == '0);
    assign head       = owner_fifo[rd_ptr];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            owner_fifo  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (push) begin
                owner_fifo[wr_ptr] <= req.owner;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
        end

    // Return path: zero-latency steering; a beat with no owner is held, never consumed
    assign s_rd_ready = !fifo_empty && (head ? b_rd_ready : a_rd_ready);
    assign a_rd_valid = !fifo_empty && !head && s_rd_valid;
    assign b_rd_valid = !fifo_empty && head && s_rd_valid;
    assign a_rd_data  = s_rd_data;
    assign a_rd_keep  = s_rd_keep;
    assign a_rd_last  = s_rd_last;
    assign b_rd_data  = s_rd_data;
    assign b_rd_keep  = s_rd_keep;
    assign b_rd_last  = s_rd_last;

    assign busy = (state == ISSUE) || !fifo_empty;

endmodule

// File: tb/tb_sgd_mem_rd_scheduler.sv
// Randomized bench for sgd_mem_rd_scheduler: a queue-level model of requests, bursts and
// in-flight owners predicts every handshake and routing decision cycle by cycle.
module tb_sgd_mem_rd_scheduler;
  localparam int DW = 512;
  localparam int BB = DW / 8;
  localparam int MB = 4096;
  localparam int MO = 16;

  logic clk = 1'b0;
  logic rst;
  logic a_cmd_valid, a_cmd_ready, b_cmd_valid, b_cmd_ready;
  logic [63:0] a_cmd_address, b_cmd_address, m_cmd_address;
  logic [31:0] a_cmd_length, b_cmd_length, m_cmd_length;
  logic m_cmd_valid, m_cmd_ready;
  logic [7:0] m_cmd_tag;
  logic s_rd_valid, s_rd_ready, s_rd_last, a_rd_valid, a_rd_ready, a_rd_last;
  logic b_rd_valid, b_rd_ready, b_rd_last, busy;
  logic [DW-1:0] s_rd_data, a_rd_data, b_rd_data;
  logic [BB-1:0] s_rd_keep, a_rd_keep, b_rd_keep;

  always #5 clk = ~clk;

  sgd_mem_rd_scheduler #(
    .DATA_WIDTH(DW), .MAX_BURST_BYTES(MB), .MAX_OUTSTANDING(MO), .TAG_A(8'h0a), .TAG_B(8'h0b)
  ) dut (
    .clk(clk), .rst(rst),
    .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready), .a_cmd_address(a_cmd_address), .a_cmd_length(a_cmd_length),
    .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready), .b_cmd_address(b_cmd_address), .b_cmd_length(b_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_address(m_cmd_address),
    .m_cmd_length(m_cmd_length), .m_cmd_tag(m_cmd_tag),
    .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_data(s_rd_data), .s_rd_keep(s_rd_keep), .s_rd_last(s_rd_last),
    .a_rd_valid(a_rd_valid), .a_rd_ready(a_rd_ready), .a_rd_data(a_rd_data), .a_rd_keep(a_rd_keep), .a_rd_last(a_rd_last),
    .b_rd_valid(b_rd_valid), .b_rd_ready(b_rd_ready), .b_rd_data(b_rd_data), .b_rd_keep(b_rd_keep), .b_rd_last(b_rd_last),
    .busy(busy)
  );

  typedef struct { logic [63:0] addr; logic [31:0] len; } req_t;
  typedef struct { logic [63:0] addr; logic [31:0] len; bit owner; } burst_t;

  req_t   qa[$], qb[$];
  burst_t expq[$];
  bit     outq[$];
  int     memq[$];
  bit     m_pri;
  int     checks = 0, errors = 0;
  int     a_beats = 0, b_beats = 0;
  logic [63:0] log_addr[$];
  logic [31:0] log_len[$];
  logic [7:0]  log_tag[$];
  int a_pct = 100, b_pct = 100, mr_pct = 100, ar_pct = 100, br_pct = 100, mem_pct = 100;
  bit mem_en = 1'b1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic void enqueue(input req_t r, input bit owner);
    logic [63:0] a = r.addr;
    int unsigned rem = r.len;
    while (rem > 0) begin
      burst_t b;
      b.len = (rem > MB) ? MB : rem;
      b.addr = a;
      b.owner = owner;
      expq.push_back(b);
      a += 64'(b.len);
      rem -= b.len;
    end
  endfunction

  task automatic clear_logs();
    log_addr.delete(); log_len.delete(); log_tag.delete();
  endtask

  // One cycle: check outputs against the model at negedge, advance the model, drive next inputs
  task automatic step();
    bit idle, ea, eb, emv, esr, have, ho, ahs, bhs, mhs, rhs;
    @(negedge clk);
    idle = (expq.size() == 0);
    ea   = idle && a_cmd_valid && (!m_pri || !b_cmd_valid);
    eb   = idle && b_cmd_valid && (m_pri || !a_cmd_valid);
    emv  = !idle && (outq.size() < MO);
    have = (outq.size() > 0);
    ho   = have ? outq[0] : 1'b0;
    esr  = have && (ho ? b_rd_ready : a_rd_ready);
    chk("a_cmd_ready", a_cmd_ready, ea);
    chk("b_cmd_ready", b_cmd_ready, eb);
    chk("m_cmd_valid", m_cmd_valid, emv);
    chk("busy", busy, !idle || have);
    if (emv) begin
      chk("m_cmd_address", m_cmd_address, expq[0].addr);
      chk("m_cmd_length", m_cmd_length, expq[0].len);
      chk("m_cmd_tag", m_cmd_tag, expq[0].owner ? 8'h0b : 8'h0a);
    end
    chk("s_rd_ready", s_rd_ready, esr);
    chk("a_rd_valid", a_rd_valid, have && !ho && s_rd_valid);
    chk("b_rd_valid", b_rd_valid, have && ho && s_rd_valid);
    if (s_rd_valid) begin
      chk("a_rd_data", a_rd_data, s_rd_data);
      chk("b_rd_keep", b_rd_keep, s_rd_keep);
      chk("a_rd_last", a_rd_last, s_rd_last);
    end
    ahs = a_cmd_valid && ea;
    bhs = b_cmd_valid && eb;
    mhs = emv && m_cmd_ready;
    rhs = s_rd_valid && esr;
    if (rhs) begin
      if (ho) b_beats++; else a_beats++;
      memq[0]--;
      if (s_rd_last) begin outq.pop_front(); memq.pop_front(); end
    end
    if (mhs) begin
      log_addr.push_back(m_cmd_address); log_len.push_back(m_cmd_length); log_tag.push_back(m_cmd_tag);
      outq.push_back(expq[0].owner);
      memq.push_back(int'(expq[0].len) / BB);
      expq.pop_front();
    end
    if (ahs) begin m_pri = 1'b1; enqueue(qa[0], 1'b0); qa.pop_front(); end
    if (bhs) begin m_pri = 1'b0; enqueue(qb[0], 1'b1); qb.pop_front(); end
    @(posedge clk); #1;
    if (ahs) a_cmd_valid = 1'b0;
    if (bhs) b_cmd_valid = 1'b0;
    if (!a_cmd_valid && qa.size() > 0 && pct(a_pct)) begin
      a_cmd_valid = 1'b1; a_cmd_address = qa[0].addr; a_cmd_length = qa[0].len;
    end
    if (!b_cmd_valid && qb.size() > 0 && pct(b_pct)) begin
      b_cmd_valid = 1'b1; b_cmd_address = qb[0].addr; b_cmd_length = qb[0].len;
    end
    m_cmd_ready = pct(mr_pct);
    a_rd_ready  = pct(ar_pct);
    b_rd_ready  = pct(br_pct);
    if (rhs) s_rd_valid = 1'b0;
    if (!s_rd_valid && mem_en && memq.size() > 0 && pct(mem_pct)) begin
      s_rd_valid = 1'b1;
      for (int i = 0; i < DW / 32; i++) s_rd_data[i*32 +: 32] = $urandom();
      s_rd_keep = {$urandom(), $urandom()};
      s_rd_last = (memq[0] == 1);
    end
  endtask

  task automatic drain(input int limit, input string tag);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || a_cmd_valid || b_cmd_valid ||
            expq.size() > 0 || outq.size() > 0) && n < limit) begin
      step(); n++;
    end
    chk({tag, "_drain_timeout"}, n < limit, 1'b1);
    step();
  endtask

  task automatic wait_out(input int n, input int limit, input string tag);
    int k = 0;
    while (outq.size() < n && k < limit) begin step(); k++; end
    chk({tag, "_out_timeout"}, k < limit, 1'b1);
  endtask

  initial begin
    int a0, b0, ea_sum, eb_sum;
    req_t r;
    rst = 1'b1; m_pri = 1'b0;
    a_cmd_valid = 1'b1; a_cmd_address = '0; a_cmd_length = 32'd64;
    b_cmd_valid = 1'b0; b_cmd_address = '0; b_cmd_length = '0;
    m_cmd_ready = 1'b0; s_rd_valid = 1'b0; s_rd_data = '0; s_rd_keep = '0; s_rd_last = 1'b0;
    a_rd_ready = 1'b0; b_rd_ready = 1'b0;
    #1;
    chk("rst_a_cmd_ready", a_cmd_ready, 1'b0);
    chk("rst_m_cmd_valid", m_cmd_valid, 1'b0);
    chk("rst_m_cmd_address", m_cmd_address, 64'h0);
    chk("rst_m_cmd_length", m_cmd_length, 32'h0);
    chk("rst_m_cmd_tag", m_cmd_tag, 8'h0);
    chk("rst_s_rd_ready", s_rd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    a_cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Simultaneous A and B with priority on A
    clear_logs();
    qa.push_back('{64'h20000, 32'd64}); qb.push_back('{64'h30000, 32'd64});
    drain(200, "pair");
    chk("pair_count", log_tag.size(), 2);
    chk("pair_first", log_tag[0], 8'h0a);
    chk("pair_second", log_tag[1], 8'h0b);

    // Long A request split into bursts
    clear_logs(); a0 = a_beats; b0 = b_beats;
    qa.push_back('{64'h1000, 32'd10240});
    drain(2000, "split");
    chk("split_count", log_len.size(), 3);
    chk("split0_addr", log_addr[0], 64'h1000); chk("split0_len", log_len[0], 32'd4096);
    chk("split1_addr", log_addr[1], 64'h2000); chk("split1_len", log_len[1], 32'd4096);
    chk("split2_addr", log_addr[2], 64'h3000); chk("split2_len", log_len[2], 32'd2048);
    chk("split2_tag", log_tag[2], 8'h0a);
    chk("split_a_beats", a_beats - a0, 10240 / BB);
    chk("split_b_beats", b_beats - b0, 0);

    // Outstanding cap with no read data returning
    clear_logs(); mem_en = 1'b0;
    for (int i = 0; i < 20; i++) qa.push_back('{64'h40000 + 64'(i * 64), 32'd64});
    repeat (80) step();
    chk("cap_issued", log_len.size(), MO);
    chk("cap_m_cmd_valid", m_cmd_valid, 1'b0);
    mem_en = 1'b1;
    drain(500, "cap");
    chk("cap_total", log_len.size(), 20);

    // A,B,A in flight with B stalled: head-of-line blocking
    clear_logs(); mem_en = 1'b0;
    qa.push_back('{64'h50000, 32'd64}); wait_out(1, 50, "blk1");
    qb.push_back('{64'h60000, 32'd64}); wait_out(2, 50, "blk2");
    qa.push_back('{64'h70000, 32'd64}); wait_out(3, 50, "blk3");
    a0 = a_beats; b0 = b_beats;
    ar_pct = 100; br_pct = 0; mem_en = 1'b1;
    repeat (20) step();
    chk("blk_a_beats", a_beats - a0, 1);
    chk("blk_b_beats", b_beats - b0, 0);
    chk("blk_s_rd_ready", s_rd_ready, 1'b0);
    br_pct = 100;
    drain(200, "blk");
    chk("blk_a_total", a_beats - a0, 2);
    chk("blk_b_total", b_beats - b0, 1);

    // Zero-length request is accepted and dropped
    clear_logs();
    qa.push_back('{64'h5000, 32'd0});
    drain(50, "zero");
    chk("zero_no_cmd", log_len.size(), 0);
    chk("zero_busy", busy, 1'b0);

    // Randomized traffic
    a_pct = 60; b_pct = 60; mr_pct = 70; ar_pct = 75; br_pct = 75; mem_pct = 70;
    a0 = a_beats; b0 = b_beats; ea_sum = 0; eb_sum = 0;
    for (int i = 0; i < 40; i++) begin
      r.addr = {$urandom(), $urandom()} & ~64'(BB - 1);
      r.len  = 32'(BB) * ((i % 5 == 0) ? $urandom_range(60, 200) : $urandom_range(0, 40));
      if ($urandom_range(0, 1) == 0) begin qa.push_back(r); ea_sum += int'(r.len) / BB; end
      else begin qb.push_back(r); eb_sum += int'(r.len) / BB; end
    end
    drain(30000, "rand");
    chk("rand_a_beats", a_beats - a0, ea_sum);
    chk("rand_b_beats", b_beats - b0, eb_sum);
    a_pct = 100; b_pct = 100; mr_pct = 100; ar_pct = 100; br_pct = 100; mem_pct = 100;

    // Reset mid-burst with three bursts outstanding
    mem_en = 1'b0;
    qa.push_back('{64'h9000, 32'(5 * MB)});
    wait_out(3, 50, "mrst");
    rst = 1'b1; b_cmd_valid = 1'b1;
    #1;
    chk("mrst_m_cmd_valid", m_cmd_valid, 1'b0);
    chk("mrst_m_cmd_length", m_cmd_length, 32'h0);
    chk("mrst_m_cmd_tag", m_cmd_tag, 8'h0);
    chk("mrst_b_cmd_ready", b_cmd_ready, 1'b0);
    chk("mrst_s_rd_ready", s_rd_ready, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    qa.delete(); qb.delete(); expq.delete(); outq.delete(); memq.delete();
    m_pri = 1'b0; a_cmd_valid = 1'b0; b_cmd_valid = 1'b0; s_rd_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    clear_logs(); mem_en = 1'b1;
    qa.push_back('{64'hA000, 32'd128});
    drain(100, "post");
    chk("post_count", log_len.size(), 1);
    chk("post_addr", log_addr[0], 64'hA000);
    chk("post_tag", log_tag[0], 8'h0a);

    // Stray read beat with nothing outstanding is held, not accepted
    s_rd_valid = 1'b1; s_rd_last = 1'b1;
    @(negedge clk);
    chk("stray_s_rd_ready", s_rd_ready, 1'b0);
    chk("stray_a_rd_valid", a_rd_valid, 1'b0);
    chk("stray_b_rd_valid", b_rd_valid, 1'b0);
    s_rd_valid = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
